// File: rtl/pe_mb.sv
// pe_mb - systolic processing element with a pending-weight queue.
//
// Multiplies the west activation by the effective weight and adds the north
// partial sum; the result leaves south one cycle later. Weights travel
// north->south and are "eaten" (accept dropped) by the row whose ROW_ID
// matches pe_index_in, landing in a WBUF_DEPTH-deep pending queue. A switch
// token pops the queue head into the active weight register; that cycle's
// MAC already uses the popped weight.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   pe_enabled          column enable; low clears all state on the next edge
//   pe_valid_in         west: activation valid
//   pe_switch_in        west: activate next pending weight
//   pe_input_in         west: signed activation
//   pe_accept_w_in      north: weight stream valid
//   pe_weight_in        north: signed weight
//   pe_index_in         north: target row of the weight
//   pe_psum_in          north: signed partial sum
//   pe_*_out            registered south/east copies (psum_out = MAC result)
//   pe_wbuf_count       number of pending weights after the edge
//   pe_err              sticky {saturation, switch underflow, load overflow}
module pe_mb #(
  parameter int ROW_ID               = 0,
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int DATA_WIDTH_IN        = 8,
  parameter int DATA_WIDTH_ACCUM     = 32,
  parameter int WBUF_DEPTH           = 2,
  parameter int SATURATE             = 0,
  localparam int IW = $clog2(SYSTOLIC_ARRAY_WIDTH),
  localparam int CW = $clog2(WBUF_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pe_enabled,
  input  logic                        pe_valid_in,
  input  logic                        pe_switch_in,
  input  logic                        pe_accept_w_in,
  input  logic [DATA_WIDTH_IN-1:0]    pe_weight_in,
  input  logic [IW-1:0]               pe_index_in,
  input  logic [DATA_WIDTH_ACCUM-1:0] pe_psum_in,
  input  logic [DATA_WIDTH_IN-1:0]    pe_input_in,
  output logic [DATA_WIDTH_IN-1:0]    pe_weight_out,
  output logic [IW-1:0]               pe_index_out,
  output logic [DATA_WIDTH_ACCUM-1:0] pe_psum_out,
  output logic                        pe_accept_w_out,
  output logic [DATA_WIDTH_IN-1:0]    pe_input_out,
  output logic                        pe_valid_out,
  output logic                        pe_switch_out,
  output logic [CW-1:0]               pe_wbuf_count,
  output logic [2:0]                  pe_err
);

  localparam int DW = DATA_WIDTH_IN;
  localparam int A  = DATA_WIDTH_ACCUM;
  localparam int P  = 2 * DATA_WIDTH_IN;
  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;

  localparam logic [A-1:0] SAT_MAX = {1'b0, {(A-1){1'b1}}};
  localparam logic [A-1:0] SAT_MIN = {1'b1, {(A-1){1'b0}}};

  // Pending-weight storage; contents need no reset because head/count
  // decide which entries are meaningful.
  logic [DW-1:0] wbuf_mem [WBUF_DEPTH];

  logic [DW-1:0] active_reg;
  logic [PW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg;

  logic          load, full, pop_ok, push_ok, overflow, underflow;
  logic [DW-1:0] w_eff;
  logic [P-1:0]  product;
  logic [A:0]    sum_ext;
  logic [A-1:0]  sum_res;
  logic          clamp;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(WBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Queue control. The pop sees the pre-edge count, so a push into a full
  // queue survives when a pop happens in the same cycle, and a pop from an
  // empty queue underflows even if a push lands alongside it.
  always_comb begin
    load      = pe_accept_w_in && (pe_index_in == IW'(ROW_ID));
    full      = (count_reg == CW'(WBUF_DEPTH));
    pop_ok    = pe_switch_in && (count_reg != '0);
    underflow = pe_switch_in && (count_reg == '0);
    overflow  = load && full && !pop_ok;
    push_ok   = load && !overflow;
    w_eff     = pop_ok ? wbuf_mem[head_reg] : active_reg;
  end

  // MAC with one guard bit so signed overflow is visible in the top two bits.
  always_comb begin
    product = P'($signed(pe_input_in) * $signed(w_eff));
    sum_ext = {{(A + 1 - P){product[P-1]}}, product}
            + {pe_psum_in[A-1], pe_psum_in};
    clamp   = 1'b0;
    sum_res = sum_ext[A-1:0];
    if (SATURATE != 0) begin
      if (sum_ext[A:A-1] == 2'b01) begin
        clamp   = 1'b1;
        sum_res = SAT_MAX;
      end else if (sum_ext[A:A-1] == 2'b10) begin
        clamp   = 1'b1;
        sum_res = SAT_MIN;
      end
    end
  end

  // One register per queue slot, written when it is the tail of a push.
  generate
    for (genvar gi = 0; gi < WBUF_DEPTH; gi++) begin : g_wbuf
      always_ff @(posedge clk) begin
        if (push_ok && (tail_reg == PW'(gi))) begin
          wbuf_mem[gi] <= pe_weight_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_reg      <= '0;
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      pe_err          <= '0;
      pe_weight_out   <= '0;
      pe_index_out    <= '0;
      pe_psum_out     <= '0;
      pe_accept_w_out <= 1'b0;
      pe_input_out    <= '0;
      pe_valid_out    <= 1'b0;
      pe_switch_out   <= 1'b0;
    end else if (!pe_enabled) begin
      active_reg      <= '0;
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      pe_err          <= '0;
      pe_weight_out   <= '0;
      pe_index_out    <= '0;
      pe_psum_out     <= '0;
      pe_accept_w_out <= 1'b0;
      pe_input_out    <= '0;
      pe_valid_out    <= 1'b0;
      pe_switch_out   <= 1'b0;
    end else begin
      pe_weight_out   <= pe_weight_in;
      pe_index_out    <= pe_index_in;
      pe_input_out    <= pe_input_in;
      pe_valid_out    <= pe_valid_in;
      pe_switch_out   <= pe_switch_in;
      // A matching weight is consumed here even when the queue drops it.
      pe_accept_w_out <= pe_accept_w_in && !load;
      pe_psum_out     <= pe_valid_in ? sum_res : '0;

      if (pop_ok) begin
        active_reg <= wbuf_mem[head_reg];
        head_reg   <= ptr_inc(head_reg);
      end
      if (push_ok) begin
        tail_reg <= ptr_inc(tail_reg);
      end
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_reg <= count_reg - 1'b1;
      end

      pe_err <= pe_err | {clamp && pe_valid_in, underflow, overflow};
    end
  end

  assign pe_wbuf_count = count_reg;

endmodule

// File: tb/tb_pe_mb.sv
// Scoreboard bench for pe_mb: two instances (saturating and wrapping) share
// the same stimulus; a queue-based reference model predicts every output.
module tb_pe_mb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pe_enabled = 1'b1;
  logic        pe_valid_in = 1'b0;
  logic        pe_switch_in = 1'b0;
  logic        pe_accept_w_in = 1'b0;
  logic [7:0]  pe_weight_in = '0;
  logic [3:0]  pe_index_in = '0;
  logic [31:0] pe_psum_in = '0;
  logic [7:0]  pe_input_in = '0;

  logic [7:0]  s_weight_out, w_weight_out, s_input_out, w_input_out;
  logic [3:0]  s_index_out, w_index_out;
  logic [31:0] s_psum_out, w_psum_out;
  logic        s_accept_out, w_accept_out, s_valid_out, w_valid_out;
  logic        s_switch_out, w_switch_out;
  logic [1:0]  s_count, w_count;
  logic [2:0]  s_err, w_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe_mb #(.ROW_ID(3), .SYSTOLIC_ARRAY_WIDTH(16), .DATA_WIDTH_IN(8),
          .DATA_WIDTH_ACCUM(32), .WBUF_DEPTH(2), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .pe_enabled(pe_enabled),
    .pe_valid_in(pe_valid_in), .pe_switch_in(pe_switch_in),
    .pe_accept_w_in(pe_accept_w_in), .pe_weight_in(pe_weight_in),
    .pe_index_in(pe_index_in), .pe_psum_in(pe_psum_in),
    .pe_input_in(pe_input_in),
    .pe_weight_out(s_weight_out), .pe_index_out(s_index_out),
    .pe_psum_out(s_psum_out), .pe_accept_w_out(s_accept_out),
    .pe_input_out(s_input_out), .pe_valid_out(s_valid_out),
    .pe_switch_out(s_switch_out), .pe_wbuf_count(s_count), .pe_err(s_err)
  );

  pe_mb #(.ROW_ID(3), .SYSTOLIC_ARRAY_WIDTH(16), .DATA_WIDTH_IN(8),
          .DATA_WIDTH_ACCUM(32), .WBUF_DEPTH(2), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .pe_enabled(pe_enabled),
    .pe_valid_in(pe_valid_in), .pe_switch_in(pe_switch_in),
    .pe_accept_w_in(pe_accept_w_in), .pe_weight_in(pe_weight_in),
    .pe_index_in(pe_index_in), .pe_psum_in(pe_psum_in),
    .pe_input_in(pe_input_in),
    .pe_weight_out(w_weight_out), .pe_index_out(w_index_out),
    .pe_psum_out(w_psum_out), .pe_accept_w_out(w_accept_out),
    .pe_input_out(w_input_out), .pe_valid_out(w_valid_out),
    .pe_switch_out(w_switch_out), .pe_wbuf_count(w_count), .pe_err(w_err)
  );

  typedef struct {
    logic [7:0]  weight;
    logic [3:0]  index;
    logic        accept;
    logic [7:0]  act;
    logic        valid;
    logic        switch_;
    logic [31:0] psum_sat;
    logic [31:0] psum_wrap;
    logic [1:0]  count;
    logic [2:0]  err_sat;
    logic [2:0]  err_wrap;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic signed [7:0] m_q[$];
  logic signed [7:0] m_active = '0;
  logic [1:0]        m_err = '0;
  logic              m_err2 = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_active = '0;
    m_err    = '0;
    m_err2   = 1'b0;
  endtask

  task automatic step(input logic acc, input logic [3:0] idx,
                      input logic [7:0] w, input logic sw, input logic vl,
                      input logic [7:0] a, input logic [31:0] ps,
                      input logic en = 1'b1);
    exp_t e;
    logic load, full_pre, pop_ok, ovf, clamped;
    logic signed [7:0]  weff;
    logic signed [63:0] sum;
    logic [31:0] sat_res;

    pe_accept_w_in = acc; pe_index_in = idx; pe_weight_in = w;
    pe_switch_in = sw; pe_valid_in = vl; pe_input_in = a;
    pe_psum_in = ps; pe_enabled = en;

    if (!en) begin
      model_clear();
      e = '{default: '0};
    end else begin
      load     = acc && (idx == 4'd3);
      full_pre = (m_q.size() == 2);
      pop_ok   = sw && (m_q.size() > 0);
      weff     = pop_ok ? m_q[0] : m_active;
      ovf      = load && full_pre && !pop_ok;
      if (sw && !pop_ok) m_err[1] = 1'b1;
      if (ovf) m_err[0] = 1'b1;
      if (pop_ok) m_active = m_q.pop_front();
      if (load && !ovf) m_q.push_back(w);

      sum = 64'(longint'($signed(a)) * longint'(weff)) + 64'(longint'($signed(ps)));
      clamped = 1'b0;
      sat_res = sum[31:0];
      if (sum > 64'sd2147483647) begin
        sat_res = 32'h7FFF_FFFF; clamped = 1'b1;
      end else if (sum < -64'sd2147483648) begin
        sat_res = 32'h8000_0000; clamped = 1'b1;
      end
      if (vl && clamped) m_err2 = 1'b1;

      e.weight    = w;
      e.index     = idx;
      e.accept    = acc && !load;
      e.act       = a;
      e.valid     = vl;
      e.switch_   = sw;
      e.psum_sat  = vl ? sat_res : 32'h0;
      e.psum_wrap = vl ? sum[31:0] : 32'h0;
      e.count     = 2'(m_q.size());
      e.err_sat   = {m_err2, m_err};
      e.err_wrap  = {1'b0, m_err};
    end
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_val("weight_out", 64'(s_weight_out), 64'(e.weight));
    check_val("index_out", 64'(s_index_out), 64'(e.index));
    check_val("input_out", 64'(s_input_out), 64'(e.act));
    check_val("valid_out", 64'(s_valid_out), 64'(e.valid));
    check_val("switch_out", 64'(s_switch_out), 64'(e.switch_));
    check_val("accept_out_sat", 64'(s_accept_out), 64'(e.accept));
    check_val("accept_out_wrap", 64'(w_accept_out), 64'(e.accept));
    check_val("psum_sat", 64'(s_psum_out), 64'(e.psum_sat));
    check_val("psum_wrap", 64'(w_psum_out), 64'(e.psum_wrap));
    check_val("count_sat", 64'(s_count), 64'(e.count));
    check_val("count_wrap", 64'(w_count), 64'(e.count));
    check_val("err_sat", 64'(s_err), 64'(e.err_sat));
    check_val("err_wrap", 64'(w_err), 64'(e.err_wrap));
    $display("step acc=%0b idx=%0d w=%0d sw=%0b vl=%0b a=%0d ps=%h en=%0b -> psum_sat=%h psum_wrap=%h cnt=%0d err=%b/%b",
             acc, idx, $signed(w), sw, vl, $signed(a), ps, en,
             s_psum_out, w_psum_out, s_count, s_err, w_err);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_sat"}, {s_weight_out, s_index_out, s_accept_out,
              s_input_out, s_valid_out, s_switch_out, s_count, s_err},
              64'h0);
    check_val({tag, "_psum_sat"}, 64'(s_psum_out), 64'h0);
    check_val({tag, "_wrap"}, {w_weight_out, w_index_out, w_accept_out,
              w_input_out, w_valid_out, w_switch_out, w_count, w_err},
              64'h0);
    check_val({tag, "_psum_wrap"}, 64'(w_psum_out), 64'h0);
    $display("zero check %s", tag);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
  endtask

  task automatic clear();
    step(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Load/eat, then non-matching index passes the accept through
    step(1'b1, 4'd3, 8'hFB, 1'b0, 1'b0, 8'd0, 32'd0);
    step(1'b1, 4'd4, 8'hFE, 1'b0, 1'b0, 8'd0, 32'd0);
    clear();

    // Switch bypass: switch-cycle MAC already uses the queued weight
    step(1'b1, 4'd3, 8'd7, 1'b0, 1'b0, 8'd0, 32'd0);
    step(1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 8'd3, 32'd10);
    step(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 8'd1, 32'd0);
    clear();

    // Overflow: third weight dropped; then underflow on an empty queue
    step(1'b1, 4'd3, 8'd1, 1'b0, 1'b0, 8'd0, 32'd0);
    step(1'b1, 4'd3, 8'd2, 1'b0, 1'b0, 8'd0, 32'd0);
    step(1'b1, 4'd3, 8'd3, 1'b0, 1'b0, 8'd0, 32'd0);
    step(1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 8'd1, 32'd0);
    step(1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 8'd1, 32'd0);
    step(1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 8'd1, 32'd0);
    clear();

    // Full queue with simultaneous push and pop
    step(1'b1, 4'd3, 8'd11, 1'b0, 1'b0, 8'd0, 32'd0);
    step(1'b1, 4'd3, 8'd12, 1'b0, 1'b0, 8'd0, 32'd0);
    step(1'b1, 4'd3, 8'd9, 1'b1, 1'b1, 8'd1, 32'd0);
    step(1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 8'd1, 32'd0);
    step(1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 8'd1, 32'd0);
    // Empty queue with simultaneous push and pop: underflow, push lands
    step(1'b1, 4'd3, 8'd4, 1'b1, 1'b1, 8'd2, 32'd0);
    clear();

    // Saturation both directions, and valid=0 zeroes psum
    step(1'b1, 4'd3, 8'd127, 1'b0, 1'b0, 8'd0, 32'd0);
    step(1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 8'd127, 32'h7FFF_FFF0);
    step(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 8'd127, 32'h7FFF_FFF0);
    step(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 8'h80, 32'h8000_0000);

    // Clear mid-stream with count=2 and errors set
    step(1'b1, 4'd3, 8'd5, 1'b0, 1'b1, 8'd1, 32'd1);
    step(1'b1, 4'd3, 8'd6, 1'b0, 1'b1, 8'd1, 32'd1);
    step(1'b1, 4'd3, 8'd8, 1'b1, 1'b1, 8'd2, 32'd3, 1'b0);

    // Random traffic around the matching row
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(2, 4)), 8'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           32'($urandom));
    end

    // Asynchronous reset between edges; token seen during reset is lost
    step(1'b1, 4'd3, 8'd21, 1'b0, 1'b1, 8'd3, 32'd5);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_clear();
    pe_accept_w_in = 1'b1; pe_index_in = 4'd3; pe_weight_in = 8'd33;
    pe_switch_in = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    rst = 1'b0;
    step(1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 8'd1, 32'd0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_mb.md
# pe_mb

Next-generation systolic processing element: int-N × int-N multiply with accumulate into a wide psum, parametrised in operand/accumulator width. It has a configurable-depth pending-weight queue in place of a fixed double buffer, optional saturating accumulation, and sticky error flags. It tiles the systolic array exactly like the current PE. Weights flow north→south with index-match "signal eating". Activations, valid and switch flow west→east. Psums flow north→south.

## Interface
- ROW_ID, 0, static row index compared against pe_index_in
- SYSTOLIC_ARRAY_WIDTH, 16, array dimension; index width IW = $clog2(SYSTOLIC_ARRAY_WIDTH)
- DATA_WIDTH_IN, 8, signed operand width (weight, activation)
- DATA_WIDTH_ACCUM, 32, signed psum width; must be ≥ 2*DATA_WIDTH_IN
- WBUF_DEPTH, 2, pending-weight queue depth (≥1; 1 = classic double buffer)
- SATURATE, 0, 1 = clamp accumulate to signed DATA_WIDTH_ACCUM range, 0 = two's-complement wrap
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pe_enabled  in  1  column enable; low = synchronous clear
- pe_valid_in / pe_switch_in  in  1 each  west control
- pe_accept_w_in  in  1  weight stream valid (north)
- pe_weight_in  in  DATA_WIDTH_IN  weight (north)
- pe_index_in  in  IW  weight target row (north)
- pe_psum_in  in  DATA_WIDTH_ACCUM  psum (north)
- pe_input_in  in  DATA_WIDTH_IN  activation (west)
- pe_weight_out / pe_index_out / pe_psum_out / pe_accept_w_out  out  matching widths  south outputs
- pe_input_out / pe_valid_out / pe_switch_out  out  matching widths  east outputs
- pe_wbuf_count  out  $clog2(WBUF_DEPTH+1)  pending weights queued
- pe_err  out  3  sticky: [0] load overflow, [1] switch underflow, [2] saturation event

## Operation
- State: active weight register; pending FIFO of WBUF_DEPTH entries (head/tail pointers with wrap at WBUF_DEPTH, count); pe_err.
- Pass-through, each cycle when enabled: input, valid, switch, weight and index are registered to their outputs.
- Load: when pe_accept_w_in=1 and pe_index_in==ROW_ID, pe_weight_in is pushed and pe_accept_w_out is driven to 0 (eaten).
- No match: pe_accept_w_out <= pe_accept_w_in.
- Overflow: a push while full with no simultaneous pop drops the weight and sets pe_err[0]. The accept is still eaten.
- Switch: pe_switch_in=1 with count>0 pops the FIFO head into the active register. With count==0, the active weight is unchanged and pe_err[1] is set.
- Effective weight W_eff = FIFO head if (pe_switch_in && count>0), else active register. The switch-cycle MAC therefore already uses the new weight.
- Simultaneous push+pop: the pop is evaluated on the pre-edge state. When full, the push succeeds (count unchanged). When empty, the pop underflows and the push still lands (count 0→1).
- MAC: product = pe_input_in × W_eff, full 2*DATA_WIDTH_IN signed, sign-extended. sum = product + pe_psum_in computed at DATA_WIDTH_ACCUM+1 bits.
- Saturation (SATURATE=1): clamp to [−2^(A−1), 2^(A−1)−1] and set pe_err[2] when a clamp occurs. With SATURATE=0 the sum wraps and pe_err[2] stays 0.
- pe_psum_out <= pe_valid_in ? sum : 0.
- Err bits, once set, hold until rst or pe_enabled=0.

## Timing
- All outputs are registered with 1-cycle latency, input→output, in both directions.
- Reset (async) and pe_enabled=0 (sync, next edge) both force:
  - all outputs to 0, including pe_accept_w_out, pe_wbuf_count and pe_err;
  - the active weight to 0;
  - the FIFO to empty, with pointers 0.
- Reset deasserted mid-stream: the first edge after release processes inputs normally. In-flight accept/switch tokens received during reset are lost.
- pe_wbuf_count reflects the post-edge count.
- A weight loaded in cycle t can be switched in at the earliest in cycle t+1.

## Test plan
- Load/eat: WBUF_DEPTH=2, ROW_ID=3, with accept=1 and index=3, weight=−5 → next cycle accept_w_out=0, count=1, weight_out=−5, index_out=3. With index=4 → accept_w_out=1 and count unchanged.
- Switch bypass: queue holds 7, active 0; in one cycle switch=1, valid=1, input=3, psum_in=10 → psum_out=31, count=0, and a following valid with input=1, psum_in=0 → 7.
- Overflow and underflow:
  - Three loads into WBUF_DEPTH=2 → count=2, err[0]=1, and the third weight is never activated.
  - Switch with count=0 → err[1]=1, active unchanged.
- Full push+pop: count=2 with a simultaneous matching load (9) and switch → count stays 2, active=old head, and 9 is last in the queue.
- Saturation, with input=127, weight=127, psum_in=0x7FFFFFF0:
  - SATURATE=1 → psum_out=0x7FFFFFFF, err[2]=1.
  - SATURATE=0 → 0x80003EF1, err[2]=0.
  - valid=0 → psum_out=0.
- Clear: drop pe_enabled mid-stream with count=2 and err≠0 → next edge gives all outputs 0, count 0, err 0. Assert rst asynchronously between edges → outputs are 0 immediately.
